// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator and receive checker for one mesh endpoint.
// Transmits LFSR-payload packets to fixed or round-robin destinations and checks the inbound stream.
module axis_traffic_gen #(
  parameter int                 TDATAW          = 32,
  parameter int                 TDESTW          = 4,
  parameter int                 LOCAL_ID        = 0,
  parameter int                 LFSR_DW         = 8,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT    = 8'h01,
  parameter int                 NUM_PACKETS     = 8,
  parameter int                 PKT_LEN         = 4,
  parameter int                 GAP_CYCLES      = 0,
  parameter int                 DEST_MODE       = 0,
  parameter int                 FIXED_DEST      = 1,
  parameter int                 NUM_DEST        = 4,
  parameter int                 RX_BACKPRESSURE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_pkt_count,
  output logic [31:0]       rx_flit_count,
  output logic              err_len,
  output logic              err_dest,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic [TDATAW-1:0] axis_m_tdata,
  output logic              axis_m_tlast,
  output logic [TDESTW-1:0] axis_m_tdest,
  input  logic              axis_s_tvalid,
  output logic              axis_s_tready,
  input  logic [TDATAW-1:0] axis_s_tdata,
  input  logic              axis_s_tlast,
  input  logic [TDESTW-1:0] axis_s_tdest,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [TDESTW-1:0] LOCAL_W = TDESTW'(LOCAL_ID);

  // Next round-robin destination, wrapping modulo NUM_DEST and never targeting ourselves.
  function automatic logic [TDESTW-1:0] next_rr(input logic [TDESTW-1:0] p);
    int n;
    n = (int'(p) + 1) % NUM_DEST;
    if (n == LOCAL_ID) n = (n + 1) % NUM_DEST;
    return TDESTW'(n);
  endfunction

  localparam logic [TDESTW-1:0] RR_INIT = next_rr(LOCAL_W);

  logic [1:0]         state;
  logic [7:0]         flit_idx;
  logic [7:0]         gap_cnt;
  logic [LFSR_DW-1:0] lfsr;
  logic [LFSR_DW-1:0] lfsr_next;
  logic [TDESTW-1:0]  rr_ptr;
  logic [TDESTW-1:0]  pkt_dest;
  logic               m_hs;
  logic               flit_last;

  generate
    if (LFSR_DW == 16) begin : g_lfsr16
      assign lfsr_next = {lfsr[LFSR_DW-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end else begin : g_lfsr8
      assign lfsr_next = {lfsr[LFSR_DW-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  endgenerate

  // Both streams: a beat transfers on a rising edge where tvalid && tready; the transmit
  // side holds tvalid, tdata, tlast and tdest stable until that edge.
  assign axis_m_tvalid = (state == S_SEND);
  assign m_hs          = axis_m_tvalid && axis_m_tready;
  assign flit_last     = (flit_idx == 8'(PKT_LEN - 1));
  assign axis_m_tlast  = axis_m_tvalid && flit_last;
  // rr_ptr only moves at a packet boundary, so the destination is fixed for a whole packet.
  assign pkt_dest      = (DEST_MODE == 1) ? rr_ptr : TDESTW'(FIXED_DEST);
  assign axis_m_tdest  = axis_m_tvalid ? pkt_dest : '0;
  assign axis_m_tdata  = axis_m_tvalid ?
                         {LOCAL_W, {(TDATAW - TDESTW - LFSR_DW){1'b0}}, lfsr} : '0;
  assign busy          = (state != S_IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      flit_idx <= '0;
      gap_cnt  <= '0;
      tx_count <= '0;
      lfsr     <= LFSR_DEFAULT;
      rr_ptr   <= RR_INIT;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The cycle that shows DONE still rejects START.
          if (start && !done) begin
            state    <= S_SEND;
            tx_count <= '0;
            flit_idx <= '0;
          end
        end
        S_SEND: begin
          if (m_hs) begin
            lfsr <= lfsr_next;
            if (flit_last) begin
              flit_idx <= '0;
              tx_count <= tx_count + 16'd1;
              rr_ptr   <= next_rr(rr_ptr);
              if (tx_count == 16'(NUM_PACKETS - 1)) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else if (GAP_CYCLES > 0) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else begin
              flit_idx <= flit_idx + 8'd1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= S_SEND;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic       rdy_en;
  logic [1:0] bp_cnt;
  logic [7:0] rx_cnt;
  logic       s_hs;
  logic       unused_ok;

  assign axis_s_tready = rdy_en && !((RX_BACKPRESSURE != 0) && (bp_cnt == 2'd3));
  assign s_hs          = axis_s_tvalid && axis_s_tready;
  assign unused_ok     = ^axis_s_tdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en        <= 1'b0;
      bp_cnt        <= '0;
      rx_cnt        <= '0;
      rx_pkt_count  <= '0;
      rx_flit_count <= '0;
      err_len       <= 1'b0;
      err_dest      <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      bp_cnt <= bp_cnt + 2'd1;
      if (s_hs) begin
        rx_flit_count <= rx_flit_count + 32'd1;
        if (axis_s_tdest != LOCAL_W) err_dest <= 1'b1;
        if (axis_s_tlast) begin
          if (({1'b0, rx_cnt} + 9'd1) != 9'(PKT_LEN)) err_len <= 1'b1;
          rx_pkt_count <= rx_pkt_count + 16'd1;
          rx_cnt       <= '0;
        end else begin
          if (rx_cnt == 8'(PKT_LEN - 1)) err_len <= 1'b1;
          if (rx_cnt != 8'hFF) rx_cnt <= rx_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: per-cycle vector table for the transmit path,
// hand-written sequences for round-robin/gap and the receive checker.
module tb_axis_traffic_gen;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: fixed destination 1, no gap, receive back-pressure enabled.
  logic        start_a, busy_a, done_a, m_tvalid_a, m_tready_a, m_tlast_a;
  logic [15:0] tx_count_a, rx_pkt_a;
  logic [31:0] rx_flit_a, m_tdata_a, s_tdata;
  logic [3:0]  m_tdest_a, s_tdest;
  logic        err_len_a, err_dest_a, s_tvalid, s_tready_a, s_tlast;
  logic [1:0]  dbg_a;

  axis_traffic_gen #(
    .TDATAW(32), .TDESTW(4), .LOCAL_ID(0), .LFSR_DW(8), .LFSR_DEFAULT(8'h01),
    .NUM_PACKETS(2), .PKT_LEN(4), .GAP_CYCLES(0), .DEST_MODE(0), .FIXED_DEST(1),
    .NUM_DEST(4), .RX_BACKPRESSURE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .tx_count(tx_count_a), .rx_pkt_count(rx_pkt_a), .rx_flit_count(rx_flit_a),
    .err_len(err_len_a), .err_dest(err_dest_a),
    .axis_m_tvalid(m_tvalid_a), .axis_m_tready(m_tready_a), .axis_m_tdata(m_tdata_a),
    .axis_m_tlast(m_tlast_a), .axis_m_tdest(m_tdest_a),
    .axis_s_tvalid(s_tvalid), .axis_s_tready(s_tready_a), .axis_s_tdata(s_tdata),
    .axis_s_tlast(s_tlast), .axis_s_tdest(s_tdest), .dbg_state(dbg_a)
  );

  // Instance B: round-robin destinations from LOCAL_ID 1 with a 2-cycle gap.
  logic        start_b, busy_b, done_b, m_tvalid_b, m_tlast_b, s_tready_b;
  logic [15:0] tx_count_b, rx_pkt_b;
  logic [31:0] rx_flit_b, m_tdata_b;
  logic [3:0]  m_tdest_b;
  logic        err_len_b, err_dest_b;
  logic [1:0]  dbg_b;

  axis_traffic_gen #(
    .TDATAW(32), .TDESTW(4), .LOCAL_ID(1), .LFSR_DW(8), .LFSR_DEFAULT(8'h01),
    .NUM_PACKETS(4), .PKT_LEN(4), .GAP_CYCLES(2), .DEST_MODE(1), .FIXED_DEST(1),
    .NUM_DEST(4), .RX_BACKPRESSURE(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .tx_count(tx_count_b), .rx_pkt_count(rx_pkt_b), .rx_flit_count(rx_flit_b),
    .err_len(err_len_b), .err_dest(err_dest_b),
    .axis_m_tvalid(m_tvalid_b), .axis_m_tready(1'b1), .axis_m_tdata(m_tdata_b),
    .axis_m_tlast(m_tlast_b), .axis_m_tdest(m_tdest_b),
    .axis_s_tvalid(1'b0), .axis_s_tready(s_tready_b), .axis_s_tdata(32'h0),
    .axis_s_tlast(1'b0), .axis_s_tdest(4'h0), .dbg_state(dbg_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, start, tready;
    logic        busy, done, tvalid, tlast;
    logic [7:0]  data;
    logic [15:0] txc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, s, t, b, d, vld, l,
                             input logic [7:0] dat, input logic [15:0] c);
    vec_t x;
    x.rst = r; x.start = s; x.tready = t;
    x.busy = b; x.done = d; x.tvalid = vld; x.tlast = l; x.data = dat; x.txc = c;
    return x;
  endfunction

  task automatic send_flit(input logic [3:0] dest, input logic last);
    int   waited;
    logic hs;
    waited = 0;
    hs     = 1'b0;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdest  = dest;
    s_tlast  = last;
    s_tdata  = $urandom;
    while (!hs && waited < 8) begin
      hs = s_tready_a;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!hs) check("rx_handshake_timeout", 32'(hs), 32'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [3:0] first_dest);
    for (int i = 0; i < n; i++) send_flit((i == 0) ? first_dest : 4'd0, i == n - 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] exp_q[$];

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; m_tready_a = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tdest = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_tvalid", 32'(m_tvalid_a), 0);
    check("rst_tdata", m_tdata_a, 0);
    check("rst_tdest", 32'(m_tdest_a), 0);
    check("rst_tlast", 32'(m_tlast_a), 0);
    check("rst_tx_count", 32'(tx_count_a), 0);
    check("rst_rx_pkt", 32'(rx_pkt_a), 0);
    check("rst_rx_flit", rx_flit_a, 0);
    check("rst_errs", {30'd0, err_len_a, err_dest_a}, 0);
    check("rst_s_tready", 32'(s_tready_a), 0);
    check("rst_state", 32'(dbg_a), 0);
    @(negedge clk);
    rst = 1'b0;

    // Payload follows next = {q[6:0], q7^q5^q4^q3} from seed 01; the LFSR carries across runs.
    //                   r s t  b d v l  data   txc
    vecs.push_back(v(0,1,1, 1,0,1,0, 8'h01, 0));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h02, 0));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h04, 0));
    vecs.push_back(v(0,0,1, 1,0,1,1, 8'h08, 0));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h11, 1));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h23, 1));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h47, 1));
    vecs.push_back(v(0,0,1, 1,0,1,1, 8'h8E, 1));
    vecs.push_back(v(0,0,1, 0,1,0,0, 8'h00, 2));
    vecs.push_back(v(0,1,1, 0,0,0,0, 8'h00, 2));  // START while DONE shows: ignored
    vecs.push_back(v(0,1,1, 1,0,1,0, 8'h1C, 0));  // START one cycle later: accepted
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h38, 0));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h71, 0));
    vecs.push_back(v(0,0,1, 1,0,1,1, 8'hE2, 0));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'hC4, 1));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h89, 1));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h12, 1));  // flit 2 of packet 1
    vecs.push_back(v(1,0,1, 0,0,0,0, 8'h00, 0));
    vecs.push_back(v(1,0,1, 0,0,0,0, 8'h00, 0));
    vecs.push_back(v(0,0,1, 0,0,0,0, 8'h00, 0));
    vecs.push_back(v(0,1,1, 1,0,1,0, 8'h01, 0));  // reseeded run
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h02, 0));
    vecs.push_back(v(0,0,0, 1,0,1,0, 8'h02, 0));  // 3-cycle stall mid-packet
    vecs.push_back(v(0,0,0, 1,0,1,0, 8'h02, 0));
    vecs.push_back(v(0,0,0, 1,0,1,0, 8'h02, 0));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h04, 0));
    vecs.push_back(v(0,0,1, 1,0,1,1, 8'h08, 0));
    vecs.push_back(v(0,0,0, 1,0,1,1, 8'h08, 0));  // stall on the tlast flit
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h11, 1));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h23, 1));
    vecs.push_back(v(0,0,1, 1,0,1,0, 8'h47, 1));
    vecs.push_back(v(0,0,1, 1,0,1,1, 8'h8E, 1));
    vecs.push_back(v(0,0,1, 0,1,0,0, 8'h00, 2));
    vecs.push_back(v(0,0,1, 0,0,0,0, 8'h00, 2));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      start_a    = vecs[i].start;
      m_tready_a = vecs[i].tready;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
      check($sformatf("v%0d_done", i), 32'(done_a), 32'(vecs[i].done));
      check($sformatf("v%0d_tvalid", i), 32'(m_tvalid_a), 32'(vecs[i].tvalid));
      check($sformatf("v%0d_tx_count", i), 32'(tx_count_a), 32'(vecs[i].txc));
      if (vecs[i].tvalid || vecs[i].rst) begin
        check($sformatf("v%0d_tdata", i), m_tdata_a, 32'(vecs[i].data));
        check($sformatf("v%0d_tlast", i), 32'(m_tlast_a), 32'(vecs[i].tlast));
        check($sformatf("v%0d_tdest", i), 32'(m_tdest_a), vecs[i].tvalid ? 32'd1 : 32'd0);
      end
    end
    @(negedge clk);
    start_a    = 1'b0;
    m_tready_a = 1'b1;

    // Round-robin with gap on instance B: tdests 2,3,0,2 and two idle cycles between packets.
    begin
      int       cycles, pkts, in_pkt, low_run;
      logic     done_seen;
      logic [3:0] cur_dest;
      exp_q = '{32'd2, 32'd3, 32'd0, 32'd2};
      cycles = 0; pkts = 0; in_pkt = 0; low_run = 0; done_seen = 1'b0; cur_dest = '0;
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      while (!done_seen && cycles < 100) begin
        if (m_tvalid_b) begin
          if (in_pkt == 0) begin
            if (pkts > 0) check($sformatf("rr_gap_%0d", pkts), 32'(low_run), 32'd2);
            if (exp_q.size() > 0) check($sformatf("rr_dest_%0d", pkts), 32'(m_tdest_b), exp_q.pop_front());
            cur_dest = m_tdest_b;
          end else begin
            check($sformatf("rr_dest_hold_%0d_%0d", pkts, in_pkt), 32'(m_tdest_b), 32'(cur_dest));
          end
          check($sformatf("rr_src_id_%0d_%0d", pkts, in_pkt), 32'(m_tdata_b[31:28]), 32'd1);
          if (m_tlast_b) begin
            pkts++;
            in_pkt = 0;
          end else begin
            in_pkt++;
          end
          low_run = 0;
        end else begin
          low_run++;
        end
        done_seen = done_b;
        @(posedge clk);
        #1;
        cycles++;
      end
      check("rr_done_seen", 32'(done_seen), 32'd1);
      check("rr_packets", 32'(pkts), 32'd4);
      check("rr_tx_count", 32'(tx_count_b), 32'd4);
      check("rr_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Receiver back-pressure: exactly one not-ready cycle in every four, never two in a row.
    begin
      int lows, adjacent;
      logic prev;
      lows = 0; adjacent = 0; prev = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (!s_tready_a) lows++;
        if (!s_tready_a && !prev) adjacent++;
        prev = s_tready_a;
      end
      check("rx_ready_lows", 32'(lows), 32'd4);
      check("rx_ready_adjacent_lows", 32'(adjacent), 32'd0);
    end

    for (int p = 0; p < 3; p++) send_pkt(4, 4'd0);
    check("rx_good_pkts", 32'(rx_pkt_a), 32'd3);
    check("rx_good_flits", rx_flit_a, 32'd12);
    check("rx_good_err_len", 32'(err_len_a), 32'd0);
    check("rx_good_err_dest", 32'(err_dest_a), 32'd0);

    send_pkt(3, 4'd0);
    check("rx_short_err_len", 32'(err_len_a), 32'd1);
    check("rx_short_err_dest", 32'(err_dest_a), 32'd0);
    check("rx_short_pkts", 32'(rx_pkt_a), 32'd4);
    send_pkt(4, 4'd1);
    check("rx_misroute_err_dest", 32'(err_dest_a), 32'd1);
    send_pkt(4, 4'd0);
    check("rx_sticky_err_len", 32'(err_len_a), 32'd1);
    check("rx_sticky_err_dest", 32'(err_dest_a), 32'd1);
    check("rx_final_pkts", 32'(rx_pkt_a), 32'd6);
    check("rx_final_flits", rx_flit_a, 32'd23);

    // Overlong packet: a non-tlast flit at the last position flags a length error by itself.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rx_rst_clears_err_len", 32'(err_len_a), 32'd0);
    check("rx_rst_clears_flits", rx_flit_a, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send_flit(4'd0, 1'b0);
    check("rx_long_no_err_yet", 32'(err_len_a), 32'd0);
    send_flit(4'd0, 1'b0);
    check("rx_long_err_len", 32'(err_len_a), 32'd1);
    check("rx_long_err_dest", 32'(err_dest_a), 32'd0);
    check("rx_long_pkts", 32'(rx_pkt_a), 32'd0);
    check("rx_long_flits", rx_flit_a, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
